sprite_reader: RTL and testbench
================================

// Module: sprite_reader
// PURPOSE
//  Streams one WIDTH x HEIGHT 1-bit sprite out of asset_mem as screen pixels. On start, walks the
//  sprite raster-order and drives asset_mem's addr/ce. Absorbs the memory's 1-cycle registered read.
//  Emits (x, y, pixel) beats over valid/ready to the framebuffer writer. Clips off-screen pixels.
// PARAMETERS
//  MEM_SIZE      1024  depth of the asset_mem instance; MEM_ADDR_W = $clog2(MEM_SIZE)
//  BASE_ADDR     0     address of sprite pixel (0,0) in asset_mem
//  WIDTH         32    sprite width in pixels (>=1)
//  HEIGHT        24    sprite height in pixels (>=1); BASE_ADDR+WIDTH*HEIGHT <= MEM_SIZE
//  SCREEN_WIDTH  640   pixels with x >= SCREEN_WIDTH are clipped
//  SCREEN_HEIGHT 480   pixels with y >= SCREEN_HEIGHT are clipped
//  X_W / Y_W     10/9  width of screen coordinates
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           asynchronous, active-low reset
//  start      in   1           1-cycle request to draw; sampled only in IDLE
//  sprite_x   in   X_W         top-left x, captured on accepted start
//  sprite_y   in   Y_W         top-left y, captured on accepted start
//  busy       out  1           high from accepted start until done pulse inclusive
//  done       out  1           1-cycle pulse: last beat accepted (or drain finished if all clipped)
//  mem_ce     out  1           asset_mem ce
//  mem_addr   out  MEM_ADDR_W  asset_mem addr
//  mem_out    in   1           asset_mem out, valid the cycle after mem_ce
//  out_valid  out  1           beat valid
//  out_ready  in   1           downstream accept
//  out_x      out  X_W         screen x of beat
//  out_y      out  Y_W         screen y of beat
//  out_pixel  out  1           sprite bit (1 = opaque); equals mem_out while out_valid
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, counters 0; busy=0, done=0, mem_ce=0, out_valid=0,
//   mem_addr=BASE_ADDR, out_x=0, out_y=0.
//  FSM IDLE -> RUN on start. RUN -> DRAIN after issuing pixel (WIDTH-1, HEIGHT-1).
//   DRAIN -> IDLE when stage 1 is empty or its beat is accepted. done pulses on that transition.
//   start is ignored outside IDLE.
//  Pipeline: stage 0 holds col/row counters and a running address (start BASE_ADDR, +1 per issue).
//   No multiplier. Stage 1 holds s1_valid, out_x, out_y.
//   advance = !s1_valid || out_ready.
//  In RUN with advance: mem_ce=1, mem_addr=current address, counters step
//   (col wraps WIDTH-1->0 and row+1).
//   Stage 1 loads x = sprite_x+col, y = sprite_y+row, s1_valid = !clipped.
//  With advance outside RUN: mem_ce=0, s1_valid<=0.
//  Stall (!advance): mem_ce=0, so asset_mem holds out. Stage 1 and the counters hold.
//   out_pixel stays stable under backpressure.
//  out_valid = s1_valid; out_pixel = mem_out (combinational pass-through of the registered bit).
//  Coordinate add is done at X_W+1 / Y_W+1 bits.
//   A carry-out or a result >= SCREEN_* counts as clipped; no wrap onto screen.
//  Clipped pixels are still issued to memory (ce=1) but produce no beat. Throughput stays 1 pixel/clk.
//  Latency: start at cycle N -> first mem_ce at N+1 -> first out_valid at N+2 (no stall).
//   Unstalled, done at N+WIDTH*HEIGHT+2.
//  Reset mid-draw aborts at once. No done pulse and no partial beat after reset deasserts.
// STRUCTURE
//  Shared package sprite_pkg: state_t enum {IDLE, RUN, DRAIN}; SCREEN_WIDTH/HEIGHT and X_W/Y_W
//   constants reused by asset_mem, the renderer and the framebuffer writer.
//  Single module, no sub-modules.
//  asset_mem is instantiated by the parent beside this block; ce is driven only from mem_ce.
// TESTING (bench instantiates asset_mem with known pattern: bit = addr[0])
//  1 WIDTH=4,HEIGHT=2, start at (10,20), out_ready=1 -> 8 beats at x 10..13, y 20..21.
//    Pixels 0,1,0,1,... out_valid first at start+2; done at start+10.
//  2 Same, out_ready toggled 1,0,0,1,... -> identical beat sequence. out_pixel/out_x/out_y stable
//    while out_valid&&!out_ready; mem_ce=0 on every stall cycle.
//  3 Start at (638,479), WIDTH=4,HEIGHT=2 -> only beats (638,479),(639,479).
//    mem_ce still high 8 cycles; done asserted.
//  4 Start at (700,0) (fully clipped) -> zero beats; busy for 10 cycles; single done pulse.
//  5 start pulsed again during RUN with other coords -> ignored; beats match first request only.
//  6 rst=0 asynchronously mid-row with out_valid=1 -> all outputs reset same cycle.
//    After release: no beats, no done until a fresh start.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite path: the reader's FSM states and the
// screen geometry used by asset_mem, the renderer and the framebuffer writer.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int X_W           = 10;
  localparam int Y_W           = 9;

endpackage

// File: rtl/sprite_reader.sv
// sprite_reader
//   Streams one WIDTH x HEIGHT 1-bit sprite from asset_mem as screen pixels.
//   On start it walks the sprite in raster order, drives asset_mem addr/ce,
//   absorbs the memory's 1-cycle registered read and emits (x, y, pixel)
//   beats over valid/ready. Pixels that land off-screen are read but dropped.
//
// Ports
//   clk        in   single clock, posedge
//   rst        in   asynchronous, active-low reset
//   start      in   1-cycle draw request, sampled only in IDLE
//   sprite_x   in   top-left x, captured on accepted start
//   sprite_y   in   top-left y, captured on accepted start
//   busy       out  high from accepted start through the done pulse
//   done       out  1-cycle pulse once the last beat has been accepted
//   mem_ce     out  asset_mem read enable
//   mem_addr   out  asset_mem address
//   mem_out    in   asset_mem read data, valid the cycle after mem_ce
//   out_valid  out  beat valid
//   out_ready  in   downstream accept
//   out_x      out  screen x of the beat
//   out_y      out  screen y of the beat
//   out_pixel  out  sprite bit (1 = opaque)
module sprite_reader #(
  parameter int MEM_SIZE      = 1024,
  parameter int BASE_ADDR     = 0,
  parameter int WIDTH         = 32,
  parameter int HEIGHT        = 24,
  parameter int SCREEN_WIDTH  = sprite_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = sprite_pkg::SCREEN_HEIGHT,
  parameter int X_W           = sprite_pkg::X_W,
  parameter int Y_W           = sprite_pkg::Y_W,
  parameter int MEM_ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [X_W-1:0]        sprite_x,
  input  logic [Y_W-1:0]        sprite_y,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ce,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [X_W-1:0]        out_x,
  output logic [Y_W-1:0]        out_y,
  output logic                  out_pixel
);

  import sprite_pkg::*;

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [MEM_ADDR_W-1:0] ADDR_BASE = MEM_ADDR_W'(BASE_ADDR);
  localparam logic [X_W:0]          X_LIMIT   = (X_W + 1)'(SCREEN_WIDTH);
  localparam logic [Y_W:0]          Y_LIMIT   = (Y_W + 1)'(SCREEN_HEIGHT);

  state_t state, next_state;

  // Stage 0: raster position and running address (no multiplier needed).
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [MEM_ADDR_W-1:0] addr;
  logic [X_W-1:0]        base_x;
  logic [Y_W-1:0]        base_y;

  // Stage 1: beat register, aligned with asset_mem's registered output.
  logic s1_valid;
  logic done_q;

  logic         advance;
  logic         issue;
  logic         last_pixel;
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic         clipped;

  // Stage 1 may take a new beat when it is empty or its beat leaves now.
  assign advance    = !s1_valid || out_ready;
  assign issue      = (state == RUN) && advance;
  assign last_pixel = (col == COL_LAST) && (row == ROW_LAST);

  // One extra bit keeps the carry, so a sprite hanging past the top of the
  // coordinate range is clipped instead of wrapping back onto the screen.
  assign x_sum   = {1'b0, base_x} + (X_W + 1)'(col);
  assign y_sum   = {1'b0, base_y} + (Y_W + 1)'(row);
  assign clipped = x_sum[X_W] || (x_sum >= X_LIMIT) ||
                   y_sum[Y_W] || (y_sum >= Y_LIMIT);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (issue && last_pixel) next_state = DRAIN;
      DRAIN:   if (advance) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_ce    = issue;
    mem_addr  = addr;
    busy      = (state != IDLE) || done_q;
    done      = done_q;
    out_valid = s1_valid;
    // asset_mem only reloads on mem_ce, which is low during a stall, so its
    // registered output already holds the bit belonging to stage 1.
    out_pixel = mem_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col      <= '0;
      row      <= '0;
      addr     <= ADDR_BASE;
      base_x   <= '0;
      base_y   <= '0;
      s1_valid <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == DRAIN) && advance;

      if ((state == IDLE) && start) begin
        base_x <= sprite_x;
        base_y <= sprite_y;
        col    <= '0;
        row    <= '0;
        addr   <= ADDR_BASE;
      end else if (issue) begin
        addr <= addr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (advance) begin
        // A clipped pixel is still read (keeps 1 pixel/clk) but yields no beat.
        s1_valid <= issue && !clipped;
        if (issue) begin
          out_x <= x_sum[X_W-1:0];
          out_y <= y_sum[Y_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_reader.sv
// Directed bench for sprite_reader with a 4x2 sprite and an asset_mem whose
// bit at each address is addr[0]. A behavioural model lists the beats each
// accepted start must produce; one negedge process compares every accepted
// beat and the stall rules against it, and the main sequence pins latency,
// clipping, ignore-start and reset behaviour with literal expectations.
module tb_sprite_reader;

  localparam int MEM_SIZE  = 1024;
  localparam int BASE_ADDR = 0;
  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 2;
  localparam int SW        = 640;
  localparam int SH        = 480;
  localparam int X_W       = sprite_pkg::X_W;
  localparam int Y_W       = sprite_pkg::Y_W;
  localparam int AW        = $clog2(MEM_SIZE);

  typedef struct {
    int x;
    int y;
    int pix;
  } beat_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [X_W-1:0] sprite_x;
  logic [Y_W-1:0] sprite_y;
  logic           busy;
  logic           done;
  logic           mem_ce;
  logic [AW-1:0]  mem_addr;
  logic           mem_out;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic           out_pixel;

  sprite_reader #(
    .MEM_SIZE  (MEM_SIZE),
    .BASE_ADDR (BASE_ADDR),
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .busy      (busy),
    .done      (done),
    .mem_ce    (mem_ce),
    .mem_addr  (mem_addr),
    .mem_out   (mem_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_pixel (out_pixel)
  );

  // asset_mem stand-in: 1-cycle registered read, holds when ce is low.
  logic mem_bits [MEM_SIZE];
  initial begin
    for (int a = 0; a < MEM_SIZE; a++) mem_bits[a] = a[0];
    mem_out = 1'b0;
  end
  always @(posedge clk) if (mem_ce) mem_out <= mem_bits[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Requests recorded by the main sequence; the monitor turns them into beats.
  int req_seq = 0;
  int req_x   = 0;
  int req_y   = 0;

  // Monitor-owned state.
  beat_t exp_q[$];
  int    seen_seq    = 0;
  int    beats_total = 0;
  int    done_total  = 0;
  int    ce_total    = 0;
  int    busy_total  = 0;
  int    last_x      = -1;
  int    last_y      = -1;
  int    last_pix    = -1;
  bit    prev_stall  = 1'b0;
  int    prev_x      = 0;
  int    prev_y      = 0;
  int    prev_pix    = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (req_seq != seen_seq) begin
        seen_seq = req_seq;
        for (int r = 0; r < HEIGHT; r++) begin
          for (int c = 0; c < WIDTH; c++) begin
            if (req_x + c < SW && req_y + r < SH)
              exp_q.push_back('{x: req_x + c, y: req_y + r,
                                pix: (BASE_ADDR + r * WIDTH + c) % 2});
          end
        end
      end

      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_x", out_x, prev_x);
        check("stall_hold_y", out_y, prev_y);
        check("stall_hold_pixel", out_pixel, prev_pix);
      end
      if (out_valid && !out_ready) check("stall_mem_ce", mem_ce, 0);

      if (out_valid && out_ready) begin
        beats_total++;
        last_x   = int'(out_x);
        last_y   = int'(out_y);
        last_pix = int'(out_pixel);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL extra_beat: got beat (%0d,%0d) expected no beat", out_x, out_y);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_x", out_x, e.x);
          check("beat_y", out_y, e.y);
          check("beat_pixel", out_pixel, e.pix);
        end
      end

      prev_stall = out_valid && !out_ready;
      prev_x     = int'(out_x);
      prev_y     = int'(out_y);
      prev_pix   = int'(out_pixel);
      if (done)   done_total++;
      if (mem_ce) ce_total++;
      if (busy)   busy_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one cycle; returns 1 ns after the edge that accepts it.
  task automatic do_start(input int x, input int y);
    sprite_x = X_W'(x);
    sprite_y = Y_W'(y);
    start    = 1'b1;
    req_x    = x;
    req_y    = y;
    req_seq++;
    tick();
    start = 1'b0;
  endtask

  // Runs until done (bounded); optional out_ready pattern 1,0,0,1,...
  task automatic run_until_done(input int budget, input bit toggle, output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (toggle) out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    out_ready = 1'b1;
    check("done_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, dcyc, b0, d0, c0, bz0;

    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    sprite_x  = '0;
    sprite_y  = '0;

    // Reset state.
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_ce", mem_ce, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_addr", mem_addr, BASE_ADDR);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();

    // 1: basic draw, latency and done timing.
    b0 = beats_total; d0 = done_total;
    do_start(10, 20);
    n1 = cyc;
    check("t1_busy_n1", busy, 1);
    check("t1_mem_ce_n1", mem_ce, 1);
    check("t1_mem_addr_n1", mem_addr, 0);
    check("t1_valid_n1", out_valid, 0);
    tick();
    check("t1_valid_n2", out_valid, 1);
    check("t1_first_x", out_x, 10);
    check("t1_first_y", out_y, 20);
    check("t1_first_pixel", out_pixel, 0);
    run_until_done(40, 1'b0, dcyc);
    check("t1_done_latency", dcyc - n1, 9);
    check("t1_busy_at_done", busy, 1);
    tick();
    check("t1_busy_after", busy, 0);
    check("t1_beats", beats_total - b0, 8);
    check("t1_done_count", done_total - d0, 1);
    check("t1_last_x", last_x, 13);
    check("t1_last_y", last_y, 21);
    check("t1_last_pixel", last_pix, 1);
    check("t1_model_empty", exp_q.size(), 0);

    // 2: same draw under backpressure.
    b0 = beats_total; d0 = done_total;
    do_start(10, 20);
    run_until_done(80, 1'b1, dcyc);
    repeat (2) tick();
    check("t2_beats", beats_total - b0, 8);
    check("t2_done_count", done_total - d0, 1);
    check("t2_model_empty", exp_q.size(), 0);

    // 3: bottom-right corner, only two on-screen pixels.
    b0 = beats_total; d0 = done_total; c0 = ce_total;
    do_start(638, 479);
    n1 = cyc;
    run_until_done(40, 1'b0, dcyc);
    check("t3_done_latency", dcyc - n1, 9);
    repeat (2) tick();
    check("t3_beats", beats_total - b0, 2);
    check("t3_mem_ce_cycles", ce_total - c0, 8);
    check("t3_done_count", done_total - d0, 1);
    check("t3_last_x", last_x, 639);
    check("t3_last_y", last_y, 479);
    check("t3_last_pixel", last_pix, 1);

    // 4: fully clipped.
    b0 = beats_total; d0 = done_total; bz0 = busy_total;
    do_start(700, 0);
    n1 = cyc;
    run_until_done(40, 1'b0, dcyc);
    check("t4_done_latency", dcyc - n1, 9);
    repeat (3) tick();
    check("t4_beats", beats_total - b0, 0);
    check("t4_busy_cycles", busy_total - bz0, 10);
    check("t4_done_count", done_total - d0, 1);

    // 5: second start during RUN is ignored.
    b0 = beats_total; d0 = done_total;
    do_start(100, 50);
    repeat (2) tick();
    sprite_x = X_W'(200);
    sprite_y = Y_W'(60);
    start    = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(40, 1'b0, dcyc);
    repeat (3) tick();
    check("t5_beats", beats_total - b0, 8);
    check("t5_done_count", done_total - d0, 1);
    check("t5_last_x", last_x, 103);
    check("t5_last_y", last_y, 51);
    check("t5_model_empty", exp_q.size(), 0);

    // 6: asynchronous reset mid-row.
    do_start(300, 200);
    repeat (3) tick();
    check("t6_valid_before", out_valid, 1);
    #3 rst = 1'b0;
    #2;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_mem_ce", mem_ce, 0);
    check("t6_rst_mem_addr", mem_addr, BASE_ADDR);
    check("t6_rst_out_x", out_x, 0);
    check("t6_rst_out_y", out_y, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    b0 = beats_total; d0 = done_total;
    repeat (20) tick();
    check("t6_beats_after", beats_total - b0, 0);
    check("t6_done_after", done_total - d0, 0);
    check("t6_busy_after", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
